uart_byte_transmitter: RTL and testbench

//  Serializes one parallel byte into an asynchronous serial frame (start, data LSB-first,

---
 rtl/uart_byte_transmitter.sv | 166 ++++++++++++++++
 tb/tb_uart_byte_transmitter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_transmitter
//  Description : Serialises one byte into an asynchronous frame on tx_line:
//                start bit, 8 data bits LSB first, optional even parity,
//                then STOP_BITS stop bits. One byte in flight, no FIFO.
//                Optional feature macro: UART_TX_PARITY_EN (adds the parity
//                bit after the data bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_transmitter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int STOP_BITS = 1            // 1 or 2
) (
    input  logic       clk,
    input  logic       reset,              // asynchronous, active-low
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_line,
    output logic       tx_busy,
    output logic       tx_done
);

    // Cycles per bit; the counter runs 0..c_baud_div-1 for every bit.
    localparam int c_baud_div = CLK_FREQ / BAUD;
    localparam int c_cnt_w    = $clog2(c_baud_div);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(c_baud_div - 1);
    // Index of the final stop bit (stop counter is one bit wide).
    localparam logic               c_stop_last = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [7:0]           data_q, data_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_done_q, tx_done_d;

    logic                 w_bit_end;

    assign w_bit_end = (baud_cnt_q == c_cnt_max);

    // Next-state, counters and registered-output values for the next cycle.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    data_d     = tx_data;
                    state_d    = S_START;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + c_cnt_w'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + c_cnt_w'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + c_cnt_w'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    baud_cnt_d = '0;
                    if (stop_idx_q == c_stop_last) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + c_cnt_w'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still change in the same cycle as the state.
        tx_line_d = 1'b1;
        case (state_d)
            S_START: tx_line_d = 1'b0;
            S_DATA:  tx_line_d = data_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_line_d = ^data_d;
`endif
            default: tx_line_d = 1'b1;
        endcase
        tx_busy_d = (state_d != S_IDLE);
        tx_done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    end

    // State, counters and output registers; reset aborts any frame at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            data_q     <= 8'h00;
            tx_line_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            tx_line_q  <= tx_line_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx_line = tx_line_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_byte_transmitter
//  Description : Self-checking bench for uart_byte_transmitter. A frame-level
//                model predicts line/busy/done every cycle; directed tests
//                pin the model with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_byte_transmitter;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;   // 16
`ifdef UART_TX_PARITY_EN
    localparam int STOP_BITS = 2;
    localparam int PAR       = 1;
`else
    localparam int STOP_BITS = 1;
    localparam int PAR       = 0;
`endif
    localparam int FRAME = (1 + 8 + PAR + STOP_BITS) * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_line;
    logic       tx_busy;
    logic       tx_done;

    int checks   = 0;
    int failures = 0;

    uart_byte_transmitter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_line (tx_line),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    // Each entry is the expected {line, busy, done} for one future cycle.
    logic [2:0] exp_q[$];

    task automatic push_frame(input logic [7:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR != 0) bits.push_back(^d);
        for (int i = 0; i < STOP_BITS; i++) bits.push_back(1'b1);
        foreach (bits[b])
            for (int k = 0; k < DIV; k++) exp_q.push_back({bits[b], 1'b1, 1'b0});
        exp_q.push_back(3'b101);   // first idle cycle carries tx_done
    endtask

    // Compare every cycle; a request is accepted whenever the model is idle.
    always @(negedge clk) begin
        logic [2:0] e;
        if (!reset) begin
            exp_q.delete();
            e = 3'b100;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = 3'b100;
        end
        chk("model_line", {31'd0, tx_line}, {31'd0, e[2]});
        chk("model_busy", {31'd0, tx_busy}, {31'd0, e[1]});
        chk("model_done", {31'd0, tx_done}, {31'd0, e[0]});
        if (reset && !e[1] && tx_start) push_frame(tx_data);
    end

    // ---------------- capture helpers ----------------
    logic cap_line [1:400];
    int   cap_busy_cnt;
    int   done_at[$];

    // Drive a request; returns just after the accepting edge (in cycle 1).
    task automatic send(input logic [7:0] d, input logic hold);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_data  = d;
        @(posedge clk); #1;
        if (!hold) tx_start = 1'b0;
    endtask

    // Record n cycles; at cycle j1/j2 apply input changes effective next cycle.
    task automatic capture(input int n,
                           input int j1, input logic s1, input logic [7:0] d1,
                           input int j2, input logic s2, input logic [7:0] d2);
        cap_busy_cnt = 0;
        done_at.delete();
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            cap_line[j] = tx_line;
            if (tx_busy) cap_busy_cnt++;
            if (tx_done) done_at.push_back(j);
            @(posedge clk); #1;
            if (j == j1) begin tx_start = s1; tx_data = d1; end
            if (j == j2) begin tx_start = s2; tx_data = d2; end
        end
    endtask

    initial begin
        logic [9:0] pat;
        int line_low;

        reset    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Test 1: idle after reset
        capture(50, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        line_low = 0;
        for (int j = 1; j <= 50; j++) if (!cap_line[j]) line_low++;
        chk("idle_line_low_cycles", line_low, 0);
        chk("idle_busy_cycles", cap_busy_cnt, 0);
        chk("idle_done_pulses", done_at.size(), 0);

        // Test 2: single frame, 8'hA5
        send(8'hA5, 1'b0);
        capture(FRAME + 10, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
`ifndef UART_TX_PARITY_EN
        pat = 10'b1101001010;   // start, A5 LSB first, stop
        for (int k = 0; k < 10; k++)
            chk("a5_bit_mid", {31'd0, cap_line[16*k + 8]}, {31'd0, pat[k]});
        chk("a5_busy_cycles", cap_busy_cnt, 160);
        chk("a5_done_count", done_at.size(), 1);
        if (done_at.size() > 0) chk("a5_done_cycle", done_at[0], 161);
`else
        pat = 10'd0;
        chk("a5_busy_cycles", cap_busy_cnt, FRAME);
        chk("a5_done_count", done_at.size(), 1);
`endif
        chk("a5_line_first", {31'd0, cap_line[1]}, 32'd0);
        chk("a5_line_before", {31'd0, cap_line[16]}, 32'd0);
        chk("a5_line_after", {31'd0, cap_line[17]}, 32'd1);
        repeat (20) @(posedge clk);

        // Test 3: tx_start held, 8'h00 then 8'hFF -> back-to-back frames
        send(8'h00, 1'b1);
        capture(2*FRAME + 20, 1, 1'b1, 8'hFF, 200, 1'b0, 8'hFF);
        chk("b2b_done_count", done_at.size(), 2);
        if (done_at.size() == 2) begin
            chk("b2b_done1", done_at[0], FRAME + 1);
            chk("b2b_done2", done_at[1], 2*FRAME + 2);
        end
        chk("b2b_f1_data_bit", {31'd0, cap_line[DIV + 8]}, 32'd0);
        chk("b2b_f2_start", {31'd0, cap_line[FRAME + 2]}, 32'd0);
        chk("b2b_f2_data_bit", {31'd0, cap_line[FRAME + 2 + DIV + 8]}, 32'd1);
        chk("b2b_busy_cycles", cap_busy_cnt, 2*FRAME);
        repeat (20) @(posedge clk);

        // Test 4: request during a frame is ignored
        send(8'h5A, 1'b0);
        capture(FRAME + 60, 39, 1'b1, 8'hFF, 40, 1'b0, 8'hFF);
        chk("ign_done_count", done_at.size(), 1);
        chk("ign_busy_cycles", cap_busy_cnt, FRAME);
        chk("ign_bit1_of_5a", {31'd0, cap_line[2*DIV + 8]}, 32'd1);  // 5A bit1 = 1
        chk("ign_bit2_of_5a", {31'd0, cap_line[3*DIV + 8]}, 32'd0);  // 5A bit2 = 0
        repeat (20) @(posedge clk);

        // Test 5: reset at cycle 70 of an 8'h3C frame
        send(8'h3C, 1'b0);
        repeat (69) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_line_now", {31'd0, tx_line}, 32'd1);
        chk("rst_busy_now", {31'd0, tx_busy}, 32'd0);
        capture(5, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        chk("rst_no_done", done_at.size(), 0);
        reset = 1'b1;
        send(8'h3C, 1'b0);
        capture(FRAME + 10, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        chk("rst_new_done_count", done_at.size(), 1);
        if (done_at.size() > 0) chk("rst_new_done_cycle", done_at[0], FRAME + 1);
        chk("rst_3c_bit2", {31'd0, cap_line[3*DIV + 8]}, 32'd1);    // 3C bit2 = 1
        repeat (20) @(posedge clk);

`ifdef UART_TX_PARITY_EN
        // Test 6: parity, two stop bits, 8'h07
        send(8'h07, 1'b0);
        capture(210, 0, 1'b0, 8'h00, 0, 1'b0, 8'h00);
        chk("par_bit", {31'd0, cap_line[9*16 + 8]}, 32'd1);
        chk("par_stop1", {31'd0, cap_line[10*16 + 8]}, 32'd1);
        chk("par_busy_cycles", cap_busy_cnt, 192);
        if (done_at.size() > 0) chk("par_done_cycle", done_at[0], 193);
        else chk("par_done_count", done_at.size(), 1);
        repeat (10) @(posedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
